// File: rtl/clock_forwarder_pkg.sv
// Shared types and helpers for the forwarded-clock generator.
package clock_forwarder_pkg;

   // Default half-period width and the smallest legal half period.
   localparam int DIV_W_DEF = 8;
   localparam int DIV_MIN   = 1;

   // Working width of eff_div; callers cast to and from their own DIV_W.
   localparam int EFF_W     = 32;

   // Top-level controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   // A requested half period of 0 is treated as the minimum of one cycle.
   function automatic logic [EFF_W-1:0] eff_div(input logic [EFF_W-1:0] div);
      return (div == '0) ? EFF_W'(DIV_MIN) : div;
   endfunction

endpackage

// File: rtl/clock_forwarder_if.sv
// Control and status bundle of the clock forwarder.
interface clock_forwarder_if #(
   parameter int DIV_W = 8
);
   import clock_forwarder_pkg::*;

   // There is no valid/ready handshake on this bundle: i_EN and i_DIV are
   // levels sampled on every rising i_CLK edge, o_CLK_OUT/o_RUNNING/o_BUSY are
   // registered levels, and o_RISE/o_FALL/o_DIV_ACK are single-cycle pulses
   // aligned with the o_CLK_OUT edge they describe.
   logic             i_EN;
   logic [DIV_W-1:0] i_DIV;
   logic             o_CLK_OUT;
   logic             o_RUNNING;
   logic             o_BUSY;
   logic             o_RISE;
   logic             o_FALL;
   logic             o_DIV_ACK;
   state_t           dbg_state;

   // Side that requests the clock and watches its status.
   modport master (
      output i_EN,
      output i_DIV,
      input  o_CLK_OUT,
      input  o_RUNNING,
      input  o_BUSY,
      input  o_RISE,
      input  o_FALL,
      input  o_DIV_ACK,
      input  dbg_state
   );

   // The forwarder itself.
   modport slave (
      input  i_EN,
      input  i_DIV,
      output o_CLK_OUT,
      output o_RUNNING,
      output o_BUSY,
      output o_RISE,
      output o_FALL,
      output o_DIV_ACK,
      output dbg_state
   );

endinterface

// File: rtl/clkfwd_phase_counter.sv
// Phase counter: holds the active half period and counts cycles within the
// current phase, flagging the last cycle of that phase.
module clkfwd_phase_counter
   import clock_forwarder_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [DIV_W-1:0] load_value,
   input  logic             clr,
   input  logic             inc,
   output logic [DIV_W-1:0] active,
   output logic             term
);

   logic [DIV_W-1:0] count;

   // Load a new half period (restarting the count), clear, or advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         active <= DIV_W'(DIV_MIN);
      end else if (load) begin
         active <= load_value;
         count  <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   // Last cycle of the phase; the controller always clears on it, so the
   // count never runs past active-1.
   assign term = (count == active - 1'b1);

endmodule

// File: rtl/clock_forwarder.sv
// Glitch-free divided clock source. Start, stop and divide changes are only
// applied at phase boundaries so no runt pulse reaches the output pin.
module clock_forwarder
   import clock_forwarder_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic            i_CLK,
   input  logic            i_RST_N,
   clock_forwarder_if.slave bus
);

   state_t           state_q, state_d;
   logic             clk_q, clk_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             ack_q, ack_d;
   logic             cnt_load, cnt_clr, cnt_inc;
   logic [DIV_W-1:0] hp;
   logic [DIV_W-1:0] active;
   logic             term;

   // Requested half period with 0 mapped to 1.
   assign hp = DIV_W'(eff_div(EFF_W'(bus.i_DIV)));

   clkfwd_phase_counter #(
      .DIV_W (DIV_W)
   ) u_phase_counter (
      .clk        (i_CLK),
      .rst_n      (i_RST_N),
      .load       (cnt_load),
      .load_value (hp),
      .clr        (cnt_clr),
      .inc        (cnt_inc),
      .active     (active),
      .term       (term)
   );

   // Next state, next clock level and strobes.
   always_comb begin
      state_d  = state_q;
      clk_d    = clk_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      ack_d    = 1'b0;
      cnt_load = 1'b0;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            clk_d = 1'b0;
            if (bus.i_EN) begin
               state_d  = RUN;
               clk_d    = 1'b1;
               rise_d   = 1'b1;
               ack_d    = 1'b1;
               cnt_load = 1'b1;
            end
         end
         RUN: begin
            if (term) begin
               cnt_clr = 1'b1;
               if (clk_q) begin
                  // High phase complete: always fall; stop here if disabled.
                  clk_d  = 1'b0;
                  fall_d = 1'b1;
                  if (!bus.i_EN) begin
                     state_d = STOP;
                  end
               end else if (!bus.i_EN) begin
                  // Disabled on the last low cycle: the low phase is already
                  // full length, so nothing remains to count out.
                  state_d = IDLE;
               end else begin
                  // Low->high boundary is the only place the divide may change.
                  clk_d  = 1'b1;
                  rise_d = 1'b1;
                  if (hp != active) begin
                     ack_d    = 1'b1;
                     cnt_load = 1'b1;
                  end
               end
            end else begin
               cnt_inc = 1'b1;
               // Disabled mid low phase: finish the same low phase in STOP.
               if (!clk_q && !bus.i_EN) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            // Enforced low phase; i_EN is deliberately ignored here.
            clk_d = 1'b0;
            if (term) begin
               state_d = IDLE;
               cnt_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            clk_d   = 1'b0;
            cnt_clr = 1'b1;
         end
      endcase
   end

   // State, output clock and strobes registered together so they stay aligned.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q <= IDLE;
         clk_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         clk_q   <= clk_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         ack_q   <= ack_d;
      end
   end

   assign bus.o_CLK_OUT = clk_q;
   assign bus.o_RUNNING = (state_q == RUN);
   assign bus.o_BUSY    = (state_q == STOP);
   assign bus.o_RISE    = rise_q;
   assign bus.o_FALL    = fall_q;
   assign bus.o_DIV_ACK = ack_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_clock_forwarder.sv
// Bench for clock_forwarder: phase-level reference model with an expected
// queue, directed sequences with literal expectations, then random stimulus.
module tb_clock_forwarder;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   clock_forwarder_if #(.DIV_W(8)) bus ();

   clock_forwarder #(.DIV_W(8)) dut (
      .i_CLK   (clk),
      .i_RST_N (rst_n),
      .bus     (bus)
   );

   // Output vector order: {clk_out, running, busy, rise, fall, div_ack}
   logic [5:0] dut_out;
   assign dut_out = {bus.o_CLK_OUT, bus.o_RUNNING, bus.o_BUSY,
                     bus.o_RISE, bus.o_FALL, bus.o_DIV_ACK};

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   // Mode 0 idle, 1 run, 2 stop. m_left counts cycles still to go in the
   // current phase (including the present one).
   int         m_mode;
   logic       m_level;
   int         m_left;
   int         m_hp;
   logic [5:0] exp_q[$];

   function automatic int hp_of(input logic [7:0] d);
      return (d == 8'd0) ? 1 : int'(d);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode  = 0;
         m_level = 1'b0;
         m_left  = 0;
         m_hp    = 1;
         exp_q.delete();
      end else begin
         logic r, f, a, en;
         int   nhp;
         r   = 1'b0;
         f   = 1'b0;
         a   = 1'b0;
         en  = bus.i_EN;
         nhp = hp_of(bus.i_DIV);
         case (m_mode)
            0: begin
               if (en) begin
                  m_mode  = 1;
                  m_level = 1'b1;
                  m_hp    = nhp;
                  m_left  = m_hp;
                  r       = 1'b1;
                  a       = 1'b1;
               end
            end
            1: begin
               if (m_left == 1) begin
                  if (m_level) begin
                     m_level = 1'b0;
                     f       = 1'b1;
                     m_left  = m_hp;
                     if (!en) m_mode = 2;
                  end else if (!en) begin
                     m_mode = 0;
                  end else begin
                     m_level = 1'b1;
                     r       = 1'b1;
                     if (nhp != m_hp) begin
                        a    = 1'b1;
                        m_hp = nhp;
                     end
                     m_left = m_hp;
                  end
               end else begin
                  m_left = m_left - 1;
                  if (!m_level && !en) m_mode = 2;
               end
            end
            default: begin
               if (m_left == 1) m_mode = 0;
               else m_left = m_left - 1;
            end
         endcase
         exp_q.push_back({m_level, m_mode == 1, m_mode == 2, r, f, a});
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         checks++;
         if (dut_out !== 6'b000000) begin
            errors++;
            $display("FAIL reset_hold t=%0t got %b required 000000", $time, dut_out);
         end
      end else if (exp_q.size() != 0) begin
         logic [5:0] e;
         e = exp_q.pop_front();
         checks++;
         if (dut_out !== e) begin
            errors++;
            $display("FAIL model_cmp t=%0t got %b required %b", $time, dut_out, e);
         end
      end
   end

   // ---------------- driver / directed tasks ----------------
   logic [5:0] seq[$];

   task automatic check_vec(input string name, input int cyc, input logic [5:0] exp);
      checks++;
      if (dut_out !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %b required %b", name, cyc, dut_out, exp);
      end
   endtask

   // Start inputs must already be applied; the next rising edge is cycle 0's
   // end. Optional input changes are applied right after checking a cycle.
   task automatic check_seq(input string name,
                            input int c1, input logic e1, input logic [7:0] d1,
                            input int c2, input logic e2, input logic [7:0] d2);
      @(posedge clk);
      for (int i = 0; i < seq.size(); i++) begin
         @(negedge clk);
         check_vec(name, i + 1, seq[i]);
         if (i + 1 == c1) begin
            bus.i_EN  = e1;
            bus.i_DIV = d1;
         end
         if (i + 1 == c2) begin
            bus.i_EN  = e2;
            bus.i_DIV = d2;
         end
      end
   endtask

   task automatic go_idle(input string name);
      bit done;
      done = 1'b0;
      bus.i_EN = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
         @(negedge clk);
         if (!bus.o_RUNNING && !bus.o_BUSY && !bus.o_CLK_OUT) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_idle_wait got timeout required idle", name);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pick_div();
      if ($urandom_range(0, 3) == 0) return 8'($urandom_range(6, 12));
      return 8'($urandom_range(0, 5));
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b1;
      bus.i_EN  = 1'b0;
      bus.i_DIV = 8'd0;
      #1 rst_n = 1'b0;
      #1 check_vec("reset_state", 0, 6'b000000);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // DIV=2 from IDLE: 1,1,0,0 repeating, ack once.
      bus.i_DIV = 8'd2;
      bus.i_EN  = 1'b1;
      seq = '{6'b110101, 6'b110000, 6'b010010, 6'b010000,
              6'b110100, 6'b110000, 6'b010010, 6'b010000};
      check_seq("div2_run", 0, 1'b1, 8'd2, 0, 1'b1, 8'd2);
      go_idle("div2");

      // DIV=0 behaves as 1: toggle every cycle.
      bus.i_DIV = 8'd0;
      bus.i_EN  = 1'b1;
      seq = '{6'b110101, 6'b010010, 6'b110100, 6'b010010, 6'b110100, 6'b010010};
      check_seq("div0_run", 0, 1'b1, 8'd0, 0, 1'b1, 8'd0);
      go_idle("div0");

      // Divide 2->3 during the first high phase: applied at the next rise.
      bus.i_DIV = 8'd2;
      bus.i_EN  = 1'b1;
      seq = '{6'b110101, 6'b110000, 6'b010010, 6'b010000, 6'b110101, 6'b110000,
              6'b110000, 6'b010010, 6'b010000, 6'b010000, 6'b110100};
      check_seq("div_change", 1, 1'b1, 8'd3, 0, 1'b1, 8'd3);
      go_idle("div_change");

      // DIV=4, disable after one high cycle: finish high, 4 busy cycles, idle.
      bus.i_DIV = 8'd4;
      bus.i_EN  = 1'b1;
      seq = '{6'b110101, 6'b110000, 6'b110000, 6'b110000, 6'b001010,
              6'b001000, 6'b001000, 6'b001000, 6'b000000, 6'b000000};
      check_seq("clean_stop", 1, 1'b0, 8'd4, 0, 1'b0, 8'd4);
      go_idle("clean_stop");

      // Re-enable while in STOP: ignored until IDLE, then a full rise.
      bus.i_DIV = 8'd4;
      bus.i_EN  = 1'b1;
      seq = '{6'b110101, 6'b110000, 6'b110000, 6'b110000, 6'b001010, 6'b001000,
              6'b001000, 6'b001000, 6'b000000, 6'b110101, 6'b110000};
      check_seq("stop_reenable", 1, 1'b0, 8'd4, 6, 1'b1, 8'd4);
      go_idle("stop_reenable");

      // Asynchronous reset while the output is high, then restart.
      bus.i_DIV = 8'd2;
      bus.i_EN  = 1'b1;
      seq = '{6'b110101};
      check_seq("pre_async_reset", 0, 1'b1, 8'd2, 0, 1'b1, 8'd2);
      #2 rst_n = 1'b0;
      #1 check_vec("async_reset", 1, 6'b000000);
      @(negedge clk);
      #1 rst_n = 1'b1;
      seq = '{6'b110101, 6'b110000, 6'b010010, 6'b010000,
              6'b110100, 6'b110000, 6'b010010, 6'b010000};
      check_seq("restart", 0, 1'b1, 8'd2, 0, 1'b1, 8'd2);

      // Random enable/divide activity with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(0, 15) == 0) bus.i_EN = ~bus.i_EN;
         if ($urandom_range(0, 9) == 0) bus.i_DIV = pick_div();
         if ($urandom_range(0, 599) == 0) begin
            rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
         end
      end
      go_idle("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
